// File: rtl/batcharger_ctrl.sv
// Battery charger control FSM: trickle / constant-current / constant-voltage
// charging with debounced threshold transitions, a charge timeout and recharge.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  host charge enable
//   vbat, ibat          digitized battery voltage / current
//   vtc, vcv_cfg, vrech trickle-exit, CV-target, recharge thresholds (vbat scale)
//   icc_cfg, itc_cfg    CC / TC current settings; iend end-of-charge current
//   tmax                timeout in 1024-cycle ticks, 0 disables the timeout
//   cc, tc, cv, pwen    one-hot mode selects and enable to the power block
//   icc, itc, vcv       config latched at the start of each charge
//   done, tout, state   charge complete, timeout flag, FSM state code
module batcharger_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] vbat,
    input  logic [7:0] ibat,
    input  logic [7:0] vtc,
    input  logic [7:0] vcv_cfg,
    input  logic [7:0] vrech,
    input  logic [7:0] icc_cfg,
    input  logic [7:0] itc_cfg,
    input  logic [7:0] iend,
    input  logic [7:0] tmax,
    output logic       cc,
    output logic       tc,
    output logic       cv,
    output logic       pwen,
    output logic [7:0] icc,
    output logic [7:0] itc,
    output logic [7:0] vcv,
    output logic       done,
    output logic       tout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TC   = 3'd1,
        S_CC   = 3'd2,
        S_CV   = 3'd3,
        S_END  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    state_e     thr_next;
    logic [1:0] dbnc_q, dbnc_d;
    logic [9:0] presc_q, presc_d;
    logic [7:0] tick_q, tick_d;
    logic       cc_q, cc_d, tc_q, tc_d, cv_q, cv_d;
    logic       pwen_q, pwen_d, done_q, done_d, tout_q, tout_d;
    logic [7:0] icc_q, icc_d, itc_q, itc_d, vcv_q, vcv_d;
    logic       dbnc_cond, dbnc_hit, charging, bad_state, timeout;

    always_comb begin
        state_d   = state_q;
        thr_next  = S_IDLE;
        dbnc_cond = 1'b0;
        charging  = 1'b0;
        bad_state = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_TC: begin
                charging  = 1'b1;
                dbnc_cond = (vbat >= vtc);
                thr_next  = S_CC;
            end
            S_CC: begin
                charging  = 1'b1;
                dbnc_cond = (vbat >= vcv_cfg);
                thr_next  = S_CV;
            end
            S_CV: begin
                charging  = 1'b1;
                dbnc_cond = (ibat < iend);
                thr_next  = S_END;
            end
            S_END: begin
                dbnc_cond = (vbat < vrech);
                thr_next  = S_IDLE;
            end
            default: bad_state = 1'b1;
        endcase

        timeout  = charging && (tmax != 8'd0) && (tick_q == tmax);
        // Counter value 3 means three earlier true cycles: this is the 4th.
        dbnc_hit = dbnc_cond && (dbnc_q == 2'd3);

        tout_d = tout_q;
        if (!en) begin
            state_d = S_IDLE;
        end else if (timeout) begin
            state_d = S_END;
            tout_d  = 1'b1;
        end else if (state_q == S_IDLE) begin
            if (vbat < vtc) begin
                state_d = S_TC;
            end else if (vbat < vcv_cfg) begin
                state_d = S_CC;
            end else begin
                state_d = S_CV;
            end
        end else if (bad_state) begin
            state_d = S_IDLE;
        end else if (dbnc_hit) begin
            state_d = thr_next;
        end
        if (state_d == S_IDLE) begin
            tout_d = 1'b0;
        end

        if ((state_d != state_q) || !dbnc_cond) begin
            dbnc_d = 2'd0;
        end else begin
            dbnc_d = dbnc_q + 2'd1;
        end

        // Timer runs across TC/CC/CV, holds in END, clears otherwise.
        presc_d = presc_q;
        tick_d  = tick_q;
        if (charging) begin
            presc_d = presc_q + 10'd1;
            if ((presc_q == 10'd1023) && (tick_q != 8'd255)) begin
                tick_d = tick_q + 8'd1;
            end
        end else if (state_q != S_END) begin
            presc_d = 10'd0;
            tick_d  = 8'd0;
        end

        icc_d = icc_q;
        itc_d = itc_q;
        vcv_d = vcv_q;
        if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
            icc_d = icc_cfg;
            itc_d = itc_cfg;
            vcv_d = vcv_cfg;
        end

        tc_d   = (state_d == S_TC);
        cc_d   = (state_d == S_CC);
        cv_d   = (state_d == S_CV);
        pwen_d = tc_d | cc_d | cv_d;
        done_d = (state_d == S_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dbnc_q  <= 2'd0;
            presc_q <= 10'd0;
            tick_q  <= 8'd0;
            cc_q    <= 1'b0;
            tc_q    <= 1'b0;
            cv_q    <= 1'b0;
            pwen_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            icc_q   <= 8'd0;
            itc_q   <= 8'd0;
            vcv_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dbnc_q  <= dbnc_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            cc_q    <= cc_d;
            tc_q    <= tc_d;
            cv_q    <= cv_d;
            pwen_q  <= pwen_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            icc_q   <= icc_d;
            itc_q   <= itc_d;
            vcv_q   <= vcv_d;
        end
    end

    assign cc    = cc_q;
    assign tc    = tc_q;
    assign cv    = cv_q;
    assign pwen  = pwen_q;
    assign done  = done_q;
    assign tout  = tout_q;
    assign icc   = icc_q;
    assign itc   = itc_q;
    assign vcv   = vcv_q;
    assign state = state_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Scoreboard bench for batcharger_ctrl: a behavioural charger model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_batcharger_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       cc, tc, cv, pwen, done, tout;
        logic [7:0] icc, itc, vcv;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] vbat, ibat, vtc, vcv_cfg, vrech;
    logic [7:0] icc_cfg, itc_cfg, iend, tmax;
    logic       cc, tc, cv, pwen, done, tout;
    logic [7:0] icc, itc, vcv;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    obs_t exp_q[$];

    // Model state: mode number, consecutive-true streak, cycles spent charging.
    int         m_mode = 0;
    int         m_streak = 0;
    int         m_cycles = 0;
    logic       m_tout = 1'b0;
    logic [7:0] m_icc = 8'd0, m_itc = 8'd0, m_vcv = 8'd0;

    batcharger_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .vbat(vbat), .ibat(ibat),
        .vtc(vtc), .vcv_cfg(vcv_cfg), .vrech(vrech),
        .icc_cfg(icc_cfg), .itc_cfg(itc_cfg), .iend(iend),
        .tmax(tmax),
        .cc(cc), .tc(tc), .cv(cv), .pwen(pwen),
        .icc(icc), .itc(itc), .vcv(vcv),
        .done(done), .tout(tout), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, cycles=%0d", cyc_n);
        $fatal(1);
    end

    // Advance the model by one rising edge using the current inputs.
    task automatic model_step();
        bit   charging, cond;
        int   ticks, nmode, nxt;
        obs_t e;
        if (rst) begin
            m_mode = 0; m_streak = 0; m_cycles = 0; m_tout = 1'b0;
            m_icc = 8'd0; m_itc = 8'd0; m_vcv = 8'd0;
        end else begin
            charging = (m_mode >= 1) && (m_mode <= 3);
            ticks = m_cycles / 1024;
            if (ticks > 255) ticks = 255;
            cond = 1'b0; nxt = 0;
            if (m_mode == 1) begin cond = (vbat >= vtc); nxt = 2; end
            if (m_mode == 2) begin cond = (vbat >= vcv_cfg); nxt = 3; end
            if (m_mode == 3) begin cond = (ibat < iend); nxt = 4; end
            if (m_mode == 4) begin cond = (vbat < vrech); nxt = 0; end
            nmode = m_mode;
            if (!en) begin
                nmode = 0;
            end else if (charging && tmax != 0 && ticks == int'(tmax)) begin
                nmode = 4;
                m_tout = 1'b1;
            end else if (m_mode == 0) begin
                nmode = (vbat < vtc) ? 1 : (vbat < vcv_cfg) ? 2 : 3;
                m_icc = icc_cfg; m_itc = itc_cfg; m_vcv = vcv_cfg;
            end else if (cond && m_streak + 1 == 4) begin
                nmode = nxt;
            end
            if (m_mode == 0) m_cycles = 0;
            else if (charging) m_cycles++;
            if (nmode != m_mode) m_streak = 0;
            else m_streak = cond ? m_streak + 1 : 0;
            if (nmode == 0) m_tout = 1'b0;
            m_mode = nmode;
        end
        e.st   = 3'(m_mode);
        e.tc   = (m_mode == 1);
        e.cc   = (m_mode == 2);
        e.cv   = (m_mode == 3);
        e.pwen = (m_mode >= 1) && (m_mode <= 3);
        e.done = (m_mode == 4);
        e.tout = m_tout;
        e.icc  = m_icc; e.itc = m_itc; e.vcv = m_vcv;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge: predict the next edge, then wait one cycle.
    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic spot(string nm, logic [7:0] act, logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: one expected bundle per clock edge.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            cyc_n++;
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, cc, tc, cv, pwen, done, tout, icc, itc, vcv};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: got st=%0d cc/tc/cv=%b%b%b pwen=%b done=%b tout=%b icc=%0d itc=%0d vcv=%0d expected st=%0d cc/tc/cv=%b%b%b pwen=%b done=%b tout=%b icc=%0d itc=%0d vcv=%0d",
                             cyc_n, a.st, a.cc, a.tc, a.cv, a.pwen, a.done, a.tout, a.icc, a.itc, a.vcv,
                             e.st, e.cc, e.tc, e.cv, e.pwen, e.done, e.tout, e.icc, e.itc, e.vcv);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0;
        vbat = 8'd100; ibat = 8'd200;
        vtc = 8'd150; vcv_cfg = 8'd188; vrech = 8'd0;
        icc_cfg = 8'd80; itc_cfg = 8'd20; iend = 8'd10; tmax = 8'd0;
        @(negedge clk);
        step(2);
        spot("reset_state", {5'd0, state}, 8'd0);
        rst = 1'b0;
        step(3);
        spot("idle_after_reset", {5'd0, state}, 8'd0);

        // Full charge cycle
        en = 1'b1;
        step();
        spot("first_edge_tc", {5'd0, state}, 8'd1);
        spot("itc_latched", itc, 8'd20);
        vbat = 8'd160;
        step(3);
        spot("tc_hold_3", {5'd0, state}, 8'd1);
        step();
        spot("tc_to_cc", {5'd0, state}, 8'd2);
        vbat = 8'd190;
        step(4);
        spot("cc_to_cv", {5'd0, state}, 8'd3);
        ibat = 8'd5;
        step(4);
        spot("cv_to_end", {5'd0, state}, 8'd4);
        spot("end_done", {7'd0, done}, 8'd1);

        // Recharge from END
        vbat = 8'd170; vrech = 8'd175;
        step(4);
        spot("end_to_idle", {5'd0, state}, 8'd0);
        step();
        spot("recharge_cc", {5'd0, state}, 8'd2);

        // Config latch and abort in CC
        icc_cfg = 8'd99;
        step(2);
        spot("icc_held", icc, 8'd80);
        en = 1'b0;
        step();
        spot("abort_idle", {5'd0, state}, 8'd0);
        spot("abort_pwen", {7'd0, pwen}, 8'd0);

        // Debounce glitch in TC
        en = 1'b1; vbat = 8'd100; ibat = 8'd200; vrech = 8'd0;
        step();
        vbat = 8'd160;
        step(3);
        vbat = 8'd140;
        step();
        vbat = 8'd160;
        step(3);
        spot("glitch_still_tc", {5'd0, state}, 8'd1);
        step();
        spot("glitch_then_cc", {5'd0, state}, 8'd2);

        // Timeout in TC, tmax=2
        en = 1'b0; tmax = 8'd2; vbat = 8'd100;
        step();
        en = 1'b1;
        step();
        step(2048);
        spot("timeout_not_yet", {5'd0, state}, 8'd1);
        step();
        spot("timeout_end", {5'd0, state}, 8'd4);
        spot("timeout_tout", {7'd0, tout}, 8'd1);
        spot("timeout_pwen", {7'd0, pwen}, 8'd0);
        step(5);
        spot("tout_held", {7'd0, tout}, 8'd1);

        // Reset beats abort and timeout in CV
        en = 1'b0; tmax = 8'd1;
        step();
        en = 1'b1; vbat = 8'd190;
        step();
        spot("start_cv", {5'd0, state}, 8'd3);
        step(1024);
        rst = 1'b1; en = 1'b0;
        step();
        spot("prio_state", {5'd0, state}, 8'd0);
        spot("prio_tout", {7'd0, tout}, 8'd0);
        spot("prio_icc", icc, 8'd0);
        rst = 1'b0;

        // Randomized episodes
        for (int ep = 0; ep < 6; ep++) begin
            vtc     = 8'($urandom_range(60, 140));
            vcv_cfg = vtc + 8'($urandom_range(10, 60));
            vrech   = 8'($urandom_range(100, 220));
            iend    = 8'($urandom_range(5, 80));
            tmax    = 8'($urandom_range(0, 1));
            en = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 7) == 0) vbat = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) ibat = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 31) == 0) icc_cfg = 8'($urandom);
                if ($urandom_range(0, 31) == 0) itc_cfg = 8'($urandom);
                en  = ($urandom_range(0, 299) != 0);
                rst = ($urandom_range(0, 799) == 0);
                step();
            end
            rst = 1'b0;
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected items left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
